// File: rtl/mc_cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset core:
// FSM states, opcode/funct encodings and the ALU operation set.
package mc_cpu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   function automatic logic [WORD_W-1:0] sext16(input logic [15:0] imm);
      return {{(WORD_W-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_reg_file.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
module mc_reg_file
   import mc_cpu_pkg::*;
#(
   parameter int RF_DEPTH = 32,
   parameter int AW       = $clog2(RF_DEPTH)
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   output logic [WORD_W-1:0] rd1,
   output logic [WORD_W-1:0] rd2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [WORD_W-1:0] wd
);

   logic [WORD_W-1:0] regs [RF_DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one req/ready memory port for fetch and data.
// Define PERF_CNT_EN to add cycle, retired-instruction and stall counters.
module multi_cycle_cpu
   import mc_cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                RF_DEPTH = 32,
   parameter int                MAX_WAIT = 0
)(
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [WORD_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   input  logic [WORD_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic [WORD_W-1:0] pc_o,
   output logic              halt_o,
   output logic              retire_o
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]       cyc_cnt_o,
   output logic [31:0]       instret_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam int AW = $clog2(RF_DEPTH);

   state_t                   state, state_nxt;
   alu_op_t                  alu_op;
   logic [WORD_W-1:0]        pc, pc_nxt, pc4, ir, a_r, b_r, alu_r, mdr;
   logic [WORD_W-1:0]        alu_res, sext, rd1, rd2, wb_data;
   logic signed [WORD_W-1:0] op_a, op_b;
   logic [5:0]               op, funct;
   logic [AW-1:0]            wb_addr;
   logic [31:0]              wait_cnt;
   logic                     legal, taken, xfer, stall, timeout;
   logic                     retire_nxt, rf_we, mem_start;

   assign op      = ir[31:26];
   assign funct   = ir[5:0];
   assign sext    = sext16(ir[15:0]);
   assign xfer    = mem_req_o & mem_ready_i;
   assign stall   = mem_req_o & ~mem_ready_i;
   assign timeout = (MAX_WAIT != 0) && stall && (wait_cnt >= 32'(MAX_WAIT));
   assign pc_o    = pc;
   assign halt_o  = (state == S_HALT);

   mc_reg_file #(.RF_DEPTH(RF_DEPTH), .AW(AW)) u_rf (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ra1   (ir[21 +: AW]),
      .ra2   (ir[16 +: AW]),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (rf_we),
      .wa    (wb_addr),
      .wd    (wb_data)
   );

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: legal  = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_op = ALU_ADD;
         default: legal = 1'b0;
      endcase
   end

   // Inline ALU; immediate forms take the sign-extended imm16 as operand B
   assign op_a = a_r;
   assign op_b = (op == OP_RTYPE) ? b_r : sext;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_SLT: alu_res = {{(WORD_W-1){1'b0}}, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   assign taken   = (op == OP_BEQ) ? (a_r == b_r) : (a_r != b_r);
   assign wb_addr = (op == OP_RTYPE) ? ir[11 +: AW] : ir[16 +: AW];
   assign wb_data = (op == OP_LW) ? mdr : alu_r;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      retire_nxt = 1'b0;
      rf_we      = 1'b0;
      case (state)
         S_FETCH: begin
            if (timeout)   state_nxt = S_HALT;
            else if (xfer) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (!legal) begin
               state_nxt = S_HALT;
            end else if (op == OP_J) begin
               pc_nxt     = {pc4[WORD_W-1:28], ir[25:0], 2'b00};
               retire_nxt = 1'b1;
               state_nxt  = S_FETCH;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op == OP_BEQ || op == OP_BNE) begin
               pc_nxt     = taken ? pc4 + (sext << 2) : pc4;
               retire_nxt = 1'b1;
               state_nxt  = S_FETCH;
            end else if (op == OP_LW || op == OP_SW) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            if (timeout) begin
               state_nxt = S_HALT;
            end else if (xfer) begin
               if (op == OP_SW) begin
                  pc_nxt     = pc4;
                  retire_nxt = 1'b1;
                  state_nxt  = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            pc_nxt     = pc4;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_HALT;
      endcase
   end

   // A new request is launched on entry to FETCH/MEM, or out of the idle reset cycle
   assign mem_start = ((state_nxt == S_FETCH) || (state_nxt == S_MEM)) &&
                      ((state_nxt != state) || !mem_req_o);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc          <= RESET_PC;
         ir          <= '0;
         retire_o    <= 1'b0;
         wait_cnt    <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         pc       <= pc_nxt;
         retire_o <= retire_nxt;
         wait_cnt <= stall ? wait_cnt + 32'd1 : '0;
         if (state == S_FETCH && xfer) ir <= mem_rdata_i;
         if (mem_start) begin
            mem_req_o <= 1'b1;
            if (state_nxt == S_MEM) begin
               mem_we_o    <= (op == OP_SW);
               mem_addr_o  <= {alu_res[WORD_W-1:2], 2'b00};
               mem_wdata_o <= b_r;
            end else begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= {pc_nxt[WORD_W-1:2], 2'b00};
            end
         end else if (xfer || state_nxt == S_HALT) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
         end
      end
   end

   // Datapath holding registers, only meaningful once their state has loaded them
   always_ff @(posedge clk_i) begin
      if (state == S_FETCH && xfer) pc4 <= pc + 32'd4;
      if (state == S_DECODE) begin
         a_r <= rd1;
         b_r <= rd2;
      end
      if (state == S_EXEC) alu_r <= alu_res;
      if (state == S_MEM && xfer) mdr <= mem_rdata_i;
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_cnt_o   <= '0;
         instret_o   <= '0;
         stall_cnt_o <= '0;
      end else if (state != S_HALT) begin
         cyc_cnt_o <= cyc_cnt_o + 32'd1;
         if (retire_o) instret_o   <= instret_o + 32'd1;
         if (stall)    stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: directed programs plus random programs checked
// against an instruction-level reference model and a wait-state memory model.
module tb_multi_cycle_cpu;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] pc;
   logic        halt, retire;

   always #5 clk = ~clk;

   multi_cycle_cpu #(.RESET_PC(32'h0), .RF_DEPTH(32), .MAX_WAIT(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ready_i (mem_ready),
      .pc_o        (pc),
      .halt_o      (halt),
      .retire_o    (retire)
   );

   logic [31:0] mem   [1024];
   logic [31:0] m_mem [1024];
   logic [31:0] m_reg [32];
   logic [31:0] m_pc;
   int          vectors = 0;
   int          errors  = 0;
   int          wait_n  = 0;
   bit          hold_low = 1'b0;
   int          unstable = 0;

   // Memory responder: wait_n wait cycles per transfer, then one ready cycle
   initial begin : mem_model
      int          wcnt;
      bit          in_txn;
      logic [31:0] t_addr, t_wd;
      logic        t_we;
      mem_ready = 1'b0;
      mem_rdata = '0;
      wcnt = 0;
      in_txn = 1'b0;
      forever begin
         @(negedge clk);
         if (!mem_req || rst) begin
            mem_ready = 1'b0;
            in_txn = 1'b0;
         end else begin
            if (mem_ready) begin
               mem_ready = 1'b0;
               in_txn = 1'b0;
            end
            if (!in_txn) begin
               in_txn = 1'b1;
               wcnt = 0;
               t_addr = mem_addr;
               t_we = mem_we;
               t_wd = mem_wdata;
            end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wd) begin
               unstable++;
            end
            if (hold_low || wcnt < wait_n) begin
               wcnt++;
            end else begin
               mem_ready = 1'b1;
               if (t_we) mem[t_addr[11:2]] = t_wd;
               else      mem_rdata = mem[t_addr[11:2]];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(int fn, int rd, int rs, int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   // Architectural reference: executes one instruction, returns its cycle cost
   task automatic model_step(output int cyc, output bit illegal);
      logic [31:0] ins, a, b, sx, res, ea, pc4;
      int          rs, rt, rd;
      ins = m_mem[m_pc[11:2]];
      rs = int'(ins[25:21]);
      rt = int'(ins[20:16]);
      rd = int'(ins[15:11]);
      a = m_reg[rs];
      b = m_reg[rt];
      sx = {{16{ins[15]}}, ins[15:0]};
      pc4 = m_pc + 32'd4;
      ea = (a + sx) & ~32'h3;
      illegal = 1'b0;
      cyc = 0;
      res = '0;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: illegal = 1'b1;
            endcase
            if (!illegal) begin
               if (rd != 0) m_reg[rd] = res;
               m_pc = pc4;
               cyc = 4 + wait_n;
            end
         end
         6'h08: begin
            if (rt != 0) m_reg[rt] = a + sx;
            m_pc = pc4;
            cyc = 4 + wait_n;
         end
         6'h23: begin
            if (rt != 0) m_reg[rt] = m_mem[ea[11:2]];
            m_pc = pc4;
            cyc = 5 + 2 * wait_n;
         end
         6'h2B: begin
            m_mem[ea[11:2]] = b;
            m_pc = pc4;
            cyc = 4 + 2 * wait_n;
         end
         6'h04, 6'h05: begin
            m_pc = (((a == b) ? 1'b1 : 1'b0) == (ins[31:26] == 6'h04)) ? pc4 + (sx << 2) : pc4;
            cyc = 3 + wait_n;
         end
         6'h02: begin
            m_pc = {pc4[31:28], ins[25:0], 2'b00};
            cyc = 2 + wait_n;
         end
         default: illegal = 1'b1;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_retire", {31'd0, retire}, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run_prog(input int n, input string tag);
      int exp_cyc, cyc;
      bit ill;
      for (int k = 0; k < n; k++) begin
         model_step(exp_cyc, ill);
         cyc = 0;
         if (ill) begin
            do begin
               @(negedge clk);
               cyc++;
            end while (halt !== 1'b1 && cyc < 50);
            check({tag, "_halt_latency"}, 32'(cyc), 32'(2 + wait_n));
            repeat (3) begin
               @(negedge clk);
               check({tag, "_halt_req"}, {31'd0, mem_req}, 32'd0);
               check({tag, "_halt_pc"}, pc, m_pc);
               check({tag, "_halt_flag"}, {31'd0, halt}, 32'd1);
            end
            return;
         end
         do begin
            @(negedge clk);
            cyc++;
         end while (retire !== 1'b1 && cyc < exp_cyc + 30);
         check({tag, "_retire_seen"}, {31'd0, retire}, 32'd1);
         check({tag, "_pc"}, pc, m_pc);
         if (k > 0) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      end
   endtask

   task automatic load_directed();
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[0]   = enc_i('h08, 1, 0, 5);
      mem[1]   = enc_i('h08, 2, 0, 7);
      mem[2]   = enc_r('h20, 3, 1, 2);
      mem[3]   = enc_i('h2B, 3, 0, 'h40);
      mem[4]   = enc_i('h04, 1, 1, 2);
      mem[5]   = enc_i('h08, 7, 0, 1);
      mem[6]   = enc_i('h08, 7, 0, 2);
      mem[7]   = enc_i('h23, 4, 0, 'h40);
      mem[8]   = enc_j('h100);
      mem[256] = enc_i('h05, 1, 1, 2);
      mem[257] = enc_r('h22, 5, 1, 2);
      mem[258] = enc_r('h2A, 6, 5, 0);
      mem[259] = enc_r('h20, 0, 1, 2);
      mem[260] = enc_i('h2B, 4, 0, 'h48);
      mem[261] = enc_i('h2B, 5, 0, 'h4C);
      mem[262] = enc_i('h2B, 6, 0, 'h50);
      mem[263] = enc_i('h2B, 0, 0, 'h54);
      mem[264] = enc_i('h2B, 5, 0, 'h5B);
      mem[265] = 32'hFC00_0000;
      for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
   endtask

   task automatic gen_random();
      int fns[5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
      int kind, rs, rt, rd;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 512; i++) begin
         kind = $urandom_range(0, 9);
         rs = $urandom_range(0, 7);
         rt = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         case (kind)
            0, 1, 2, 3, 4: mem[i] = enc_r(fns[$urandom_range(0, 4)], rd, rs, rt);
            5:       mem[i] = enc_i('h08, rt, rs, $urandom_range(0, 65535));
            6:       mem[i] = enc_i('h23, rt, 0, 'h800 + $urandom_range(0, 255));
            7:       mem[i] = enc_i('h2B, rt, 0, 'h800 + $urandom_range(0, 255));
            8:       mem[i] = enc_i(($urandom_range(0, 1) != 0) ? 'h04 : 'h05, rt, rs,
                                    $urandom_range(0, 6));
            default: mem[i] = enc_j(i + 1 + $urandom_range(0, 6));
         endcase
      end
      for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
   endtask

   initial begin : stim
      int cnt;
      rst = 1'b1;

      for (int pass = 0; pass < 2; pass++) begin
         load_directed();
         wait_n = (pass == 0) ? 0 : 2;
         unstable = 0;
         do_reset();
         run_prog(30, (pass == 0) ? "dir_w0" : "dir_w2");
         check("mem_0x40_sw_r3", mem['h40 >> 2], 32'd12);
         check("mem_0x48_lw_r4", mem['h48 >> 2], 32'd12);
         check("mem_0x4C_sub", mem['h4C >> 2], 32'hFFFF_FFFE);
         check("mem_0x50_slt", mem['h50 >> 2], 32'd1);
         check("mem_0x54_r0", mem['h54 >> 2], 32'd0);
         check("mem_0x58_misaligned", mem['h58 >> 2], 32'hFFFF_FFFE);
         check("req_stable", 32'(unstable), 32'd0);
      end

      for (int p = 0; p < 3; p++) begin
         gen_random();
         rst = 1'b1;
         wait_n = $urandom_range(0, 2);
         unstable = 0;
         do_reset();
         run_prog(40, "rand");
         for (int i = 'h200; i < 'h240; i++) check("rand_data", mem[i], m_mem[i]);
         check("rand_req_stable", 32'(unstable), 32'd0);
         // Reset lands while the next fetch request is outstanding
         check("fetch_req_before_rst", {31'd0, mem_req}, 32'd1);
         rst = 1'b1;
         #1;
         check("async_rst_req", {31'd0, mem_req}, 32'd0);
         check("async_rst_pc", pc, 32'h0);
         check("async_rst_retire", {31'd0, retire}, 32'd0);
      end

      hold_low = 1'b1;
      do_reset();
      cnt = 0;
      while (mem_req !== 1'b1 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_req_up", {31'd0, mem_req}, 32'd1);
      cnt = 0;
      while (halt !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_wait_cycles", 32'(cnt), 32'd4);
      check("timeout_req_dropped", {31'd0, mem_req}, 32'd0);
      check("timeout_pc_frozen", pc, 32'h0);
      rst = 1'b1;
      hold_low = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
